lfsr_ctrl: RTL

Command-driven controller that configures and sequences a Galois LFSR datapath. It sits directly behind the 7 user input pins and the 8 output pins of the chip-level top. The controller accepts 2-bit opcodes with 4-bit data nibbles to load taps, seed and step rate, then runs, single-steps or halts the LFSR, driving one selected byte of its state to `data_out`.

---
 rtl/lfsr_pkg.sv | 47 ++++
 rtl/lfsr_core.sv | 40 ++++
 rtl/lfsr_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the command-driven Galois LFSR controller.
// This package holds the opcodes, FSM states, CTRL nibble bit positions and reset defaults.
package lfsr_pkg;

  typedef enum logic [1:0] {
    OP_TAPS = 2'b00,
    OP_SEED = 2'b01,
    OP_CTRL = 2'b10,
    OP_RATE = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } fsm_e;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_LOAD   = 1;
  localparam int CTRL_STEP   = 2;
  localparam int CTRL_OUTSEL = 3;

  localparam logic [15:0] DEFAULT_TAPS_C = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED_C = 16'h0001;

  // Terminal count of the prescaler for a given rate: 2^rate - 1.
  function automatic logic [15:0] rate_limit(input logic [3:0] rate);
    return 16'((32'd1 << rate) - 32'd1);
  endfunction

  // Target state of a CTRL command issued from IDLE. Load has priority over step, and step over run.
  function automatic fsm_e ctrl_target(input logic [3:0] n);
    fsm_e t;
    if (n[CTRL_LOAD]) begin
      t = ST_LOAD;
    end else if (n[CTRL_STEP]) begin
      t = ST_STEP;
    end else if (n[CTRL_RUN]) begin
      t = ST_RUN;
    end else begin
      t = ST_IDLE;
    end
    return t;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois (right-shift) LFSR state register.
// Load has priority over advance; when neither enable is set, the state is held.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_SEED_C)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adv_en,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] adv_val;

  // One Galois step: shift right, fold the taps in when a 1 drops out of bit 0.
  always_comb begin
    if (state[0]) begin
      adv_val = (state >> 1) ^ taps;
    end else begin
      adv_val = state >> 1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_VAL;
    end else if (load_en) begin
      state <= load_val;
    end else if (adv_en) begin
      state <= adv_val;
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// Command controller for the LFSR: strobe synchronizer, config registers, prescaler and
// sequencing FSM. data_out carries the selected byte of the LFSR state.
module lfsr_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(DEFAULT_TAPS_C),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(DEFAULT_SEED_C)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_strobe,
  input  logic [1:0] cmd,
  input  logic [3:0] nib,
  output logic [7:0] data_out
);

  logic             sync1, sync2, sync_prev;
  logic             fire;
  opcode_e          op;
  logic             fire_taps, fire_seed, fire_ctrl, fire_rate;
  logic [WIDTH-1:0] taps, seed, state, load_val;
  logic [3:0]       rate;
  logic             out_sel, lat_run, lat_step;
  fsm_e             fsm, fsm_nxt;
  logic [15:0]      pre_cnt, pre_nxt;
  logic             tick, load_en, adv_en;

  // Strobe synchronizer and rising-edge detector; a held-high strobe fires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= cmd_strobe;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign fire      = sync2 & ~sync_prev;
  assign op        = opcode_e'(cmd);
  assign fire_taps = fire && (op == OP_TAPS);
  assign fire_seed = fire && (op == OP_SEED);
  assign fire_ctrl = fire && (op == OP_CTRL);
  assign fire_rate = fire && (op == OP_RATE);

  // Configuration registers; taps and seed shift in one nibble per command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps     <= DEFAULT_TAPS;
      seed     <= DEFAULT_SEED;
      rate     <= 4'd0;
      out_sel  <= 1'b0;
      lat_run  <= 1'b0;
      lat_step <= 1'b0;
    end else begin
      if (fire_taps) taps <= {taps[WIDTH-5:0], nib};
      if (fire_seed) seed <= {seed[WIDTH-5:0], nib};
      if (fire_rate) rate <= nib;
      if (fire_ctrl) begin
        out_sel  <= nib[CTRL_OUTSEL];
        lat_run  <= nib[CTRL_RUN];
        lat_step <= nib[CTRL_STEP];
      end
    end
  end

  assign tick = (fsm == ST_RUN) && (pre_cnt == rate_limit(rate));

  // Next-state logic and core enables. A CTRL command that leaves RUN on a tick suppresses that advance.
  always_comb begin
    fsm_nxt = fsm;
    load_en = 1'b0;
    adv_en  = 1'b0;
    case (fsm)
      ST_IDLE: begin
        if (fire_ctrl) begin
          fsm_nxt = ctrl_target(nib);
        end else begin
          fsm_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        if (lat_step) begin
          fsm_nxt = ST_STEP;
        end else if (lat_run) begin
          fsm_nxt = ST_RUN;
        end else begin
          fsm_nxt = ST_IDLE;
        end
      end
      ST_STEP: begin
        adv_en  = 1'b1;
        fsm_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (fire_ctrl && nib[CTRL_LOAD]) begin
          fsm_nxt = ST_LOAD;
        end else if (fire_ctrl && !nib[CTRL_RUN]) begin
          fsm_nxt = ST_IDLE;
        end else begin
          fsm_nxt = ST_RUN;
        end
        adv_en = tick && (fsm_nxt == ST_RUN);
      end
      default: begin
        fsm_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= ST_IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  // Prescaler: restarts on entry to RUN and on RATE. A RATE that coincides with a tick still lets that tick advance.
  always_comb begin
    if (fire_rate || (fsm_nxt == ST_RUN && fsm != ST_RUN)) begin
      pre_nxt = 16'd0;
    end else if (tick) begin
      pre_nxt = 16'd0;
    end else if (fsm == ST_RUN) begin
      pre_nxt = pre_cnt + 16'd1;
    end else begin
      pre_nxt = pre_cnt;
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 16'd0;
    end else begin
      pre_cnt <= pre_nxt;
    end
  end

  // An all-zero seed would lock the LFSR, so a load substitutes 1.
  always_comb begin
    if (seed == {WIDTH{1'b0}}) begin
      load_val = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      load_val = seed;
    end
  end

  lfsr_core #(
    .WIDTH     (WIDTH),
    .RESET_VAL (DEFAULT_SEED)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_en),
    .load_val (load_val),
    .adv_en   (adv_en),
    .taps     (taps),
    .state    (state)
  );

  // Registered output byte select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= DEFAULT_SEED[7:0];
    end else if (out_sel) begin
      data_out <= state[WIDTH-1 -: 8];
    end else begin
      data_out <= state[7:0];
    end
  end

endmodule
